// File: rtl/kong_pkg.sv
// kong_pkg
// Shared types and screen/sprite geometry for the Kong sprite animators.
//   kong_state_e  : animator state (HIDE / WALK / THROW), 2 bits
//   SPRITE_W/H    : Kong sprite size in pixels
//   SCREEN_W/H    : visible VGA area in pixels
//   sprite_fits() : true when a sprite placed at (px, py) stays on screen
package kong_pkg;

    typedef enum logic [1:0] {
        ST_HIDE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_THROW = 2'd2
    } kong_state_e;

    localparam int SPRITE_W = 177;
    localparam int SPRITE_H = 117;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    function automatic bit sprite_fits(input int px, input int py);
        return (px + SPRITE_W <= SCREEN_W) && (py + SPRITE_H <= SCREEN_H);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen
// Produces a single-cycle tick at the start of every VGA frame, no matter
// how many clk cycles the scan generator dwells on pixel (0,0).
//   clk  in  : system clock
//   rst  in  : asynchronous active-high reset
//   x    in  : scan column [9:0]
//   y    in  : scan row [8:0]
//   tick out : one clk high on the first cycle (0,0) is seen
module frame_tick_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic       tick
);

    logic sof;
    logic sof_q;

    assign sof = (x == 10'd0) && (y == 9'd0);

    // Resets high so that a release while the scan sits on (0,0) does not
    // produce a tick; the first tick then comes with the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sof_q <= 1'b1;
        end else begin
            sof_q <= sof;
        end
    end

    assign tick = sof & ~sof_q;

endmodule

// File: rtl/kong_animator.sv
// kong_animator
// Motion and animation controller for the Kong sprite. Paces Kong back and
// forth along his girder once per frame and flags barrel throws.
//   clk             in  : system clock (same as sprite stage)
//   rst             in  : asynchronous active-high reset
//   x, y            in  : VGA scan position
//   enable          in  : game running and Kong shown
//   posx, posy      out : sprite top-left corner
//   animation_state out : 0 = stand/walk, 1 = arms-up/throw
//   isplay          out : sprite visible
//   throw_pulse     out : one-clk pulse as a throw starts
// Build option: define KONG_THROW_EN to include the THROW state, the throw
// period counter and the throw hold timer. Without it Kong only walks and
// throw_pulse is tied low.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_HIDE  | sprite hidden, parked at X_MIN; waits for a tick with enable
// ST_WALK  | visible, moves STEP px per frame, bounces between X_MIN/X_MAX
// ST_THROW | visible, position frozen, arms up for THROW_HOLD frames
module kong_animator
    import kong_pkg::*;
#(
    parameter int X_MIN        = 40,
    parameter int X_MAX        = 423,
    parameter int Y_POS        = 40,
    parameter int STEP         = 2,
    parameter int FRAME_DIV    = 8,
    parameter int THROW_PERIOD = 120,
    parameter int THROW_HOLD   = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       enable,
    output logic [9:0] posx,
    output logic [8:0] posy,
    output logic       animation_state,
    output logic       isplay,
    output logic       throw_pulse
);

    localparam int AW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    if (!sprite_fits(X_MAX, Y_POS) || (X_MIN >= X_MAX) || (STEP < 1) ||
        (FRAME_DIV < 1) || (THROW_PERIOD < 1) || (THROW_HOLD < 1)) begin : g_bad_cfg
        $error("kong_animator: illegal parameter set");
    end

    logic tick;

    frame_tick_gen u_tick (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .y    (y),
        .tick (tick)
    );

    kong_state_e     state_q, state_d;
    logic [9:0]      posx_q, posx_d;
    logic [8:0]      posy_q;
    logic            dir_q, dir_d;
    logic            anim_q, anim_d;
    logic            isplay_q, isplay_d;
    logic            pulse_q, pulse_d;
    logic [AW-1:0]   anim_cnt_q, anim_cnt_d;

`ifdef KONG_THROW_EN
    localparam int TW = (THROW_PERIOD > 1) ? $clog2(THROW_PERIOD) : 1;
    localparam int HW = (THROW_HOLD > 1) ? $clog2(THROW_HOLD) : 1;

    logic [TW-1:0]   throw_cnt_q, throw_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            throw_due;
    logic            hold_done;

    assign throw_due = (throw_cnt_q == TW'(THROW_PERIOD - 1));
    // Hold timer is loaded with THROW_HOLD-1 on entry and counts down.
    assign hold_done = (hold_cnt_q == '0);
`endif

    // One WALK step, compared in 11 bits so posx+STEP cannot wrap.
    logic [10:0] right_sum;
    logic [9:0]  walk_posx;
    logic        walk_dir;
    logic        anim_wrap;

    assign right_sum = {1'b0, posx_q} + 11'(STEP);
    assign anim_wrap = (anim_cnt_q == AW'(FRAME_DIV - 1));

    always_comb begin
        walk_posx = posx_q;
        walk_dir  = dir_q;
        if (!dir_q) begin
            if (right_sum >= 11'(X_MAX)) begin
                walk_posx = 10'(X_MAX);
                walk_dir  = 1'b1;
            end else begin
                walk_posx = right_sum[9:0];
            end
        end else begin
            if ({1'b0, posx_q} <= 11'(X_MIN + STEP)) begin
                walk_posx = 10'(X_MIN);
                walk_dir  = 1'b0;
            end else begin
                walk_posx = posx_q - 10'(STEP);
            end
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HIDE;
            posx_q      <= 10'(X_MIN);
            posy_q      <= 9'(Y_POS);
            dir_q       <= 1'b0;
            anim_q      <= 1'b0;
            isplay_q    <= 1'b0;
            pulse_q     <= 1'b0;
            anim_cnt_q  <= '0;
`ifdef KONG_THROW_EN
            throw_cnt_q <= '0;
            hold_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            posx_q      <= posx_d;
            posy_q      <= 9'(Y_POS);
            dir_q       <= dir_d;
            anim_q      <= anim_d;
            isplay_q    <= isplay_d;
            pulse_q     <= pulse_d;
            anim_cnt_q  <= anim_cnt_d;
`ifdef KONG_THROW_EN
            throw_cnt_q <= throw_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    // Next state. Dropping enable wins over everything, tick or not.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_HIDE;
        end else if (tick) begin
            case (state_q)
                ST_HIDE: state_d = ST_WALK;
`ifdef KONG_THROW_EN
                ST_WALK: begin
                    if (throw_due) begin
                        state_d = ST_THROW;
                    end
                end
                ST_THROW: begin
                    if (hold_done) begin
                        state_d = ST_WALK;
                    end
                end
`else
                ST_WALK: state_d = ST_WALK;
`endif
                default: state_d = ST_HIDE;
            endcase
        end
    end

    // Datapath next values. Keyed on state_d so every output is already
    // correct in the first cycle the new state is visible.
    always_comb begin
        posx_d      = posx_q;
        dir_d       = dir_q;
        anim_d      = anim_q;
        anim_cnt_d  = anim_cnt_q;
        pulse_d     = 1'b0;
        isplay_d    = (state_d != ST_HIDE);
`ifdef KONG_THROW_EN
        throw_cnt_d = throw_cnt_q;
        hold_cnt_d  = hold_cnt_q;
`endif
        if (state_d == ST_HIDE) begin
            posx_d      = 10'(X_MIN);
            dir_d       = 1'b0;
            anim_d      = 1'b0;
            anim_cnt_d  = '0;
`ifdef KONG_THROW_EN
            throw_cnt_d = '0;
            hold_cnt_d  = '0;
`endif
        end else if (tick) begin
            case (state_q)
                ST_WALK: begin
                    // A bounce and a throw on the same tick both apply.
                    posx_d = walk_posx;
                    dir_d  = walk_dir;
                    if (anim_wrap) begin
                        anim_cnt_d = '0;
                        anim_d     = ~anim_q;
                    end else begin
                        anim_cnt_d = anim_cnt_q + AW'(1);
                    end
`ifdef KONG_THROW_EN
                    if (throw_due) begin
                        throw_cnt_d = '0;
                        hold_cnt_d  = HW'(THROW_HOLD - 1);
                        pulse_d     = 1'b1;
                        anim_d      = 1'b1;
                    end else begin
                        throw_cnt_d = throw_cnt_q + TW'(1);
                    end
`endif
                end
`ifdef KONG_THROW_EN
                ST_THROW: begin
                    if (hold_done) begin
                        anim_d     = 1'b0;
                        anim_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign posx            = posx_q;
    assign posy            = posy_q;
    assign animation_state = anim_q;
    assign isplay          = isplay_q;
    assign throw_pulse     = pulse_q;

endmodule
